ibex_fetch_req_scheduler: RTL and testbench

IBEX_FETCH_REQ_SCHEDULER -- requirements
Module: ibex_fetch_req_scheduler

---
 rtl/ibex_fetch_req_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_ibex_fetch_req_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_scheduler.sv
// ---------------------------------------------------------------------------
// ibex_fetch_req_scheduler
//
// Issues word-aligned instruction-memory requests on behalf of the core,
// limits the number of requests in flight to NUM_REQS, and forwards the
// in-order responses to the fetch FIFO in the same cycle they arrive.
// A branch redirects the fetch address, clears the FIFO and marks every
// response still in flight (including a request parked waiting for grant)
// to be dropped.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   req_i                      fetch enable from the core
//   branch_i, branch_addr_i    redirect pulse and halfword-aligned target
//   busy_o                     a request is outstanding or waiting for grant
//   instr_req_o/gnt_i/addr_o   instruction-memory request channel
//   instr_rvalid_i/rdata_i/err_i  instruction-memory response channel
//   fifo_clear_o               flush of the fetch FIFO (follows branch_i)
//   fifo_valid_o/ready_i       response handshake into the fetch FIFO
//   fifo_addr_o                redirect target or next fetch address
//   fifo_rdata_o/err_o         response payload into the fetch FIFO
// ---------------------------------------------------------------------------
module ibex_fetch_req_scheduler #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        busy_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        fifo_clear_o,
  output logic        fifo_valid_o,
  input  logic        fifo_ready_i,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_err_o
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_GNT = 1'b1;
  localparam logic [2:0] MAX_OUT     = 3'(NUM_REQS);

  logic [0:0]  r_state;
  logic [2:0]  r_outstanding;
  logic [2:0]  r_discard_cnt;
  logic        r_discard_next;
  logic [31:0] r_fetch_addr;
  logic [31:0] r_addr_hold;

  logic [0:0]  w_state_n;
  logic [2:0]  w_outstanding_n;
  logic [2:0]  w_discard_cnt_n;
  logic        w_discard_next_n;
  logic [31:0] w_fetch_addr_n;
  logic [31:0] w_addr_hold_n;

  logic        w_in_wait;
  logic        w_can_issue;
  logic        w_grant;
  logic        w_rvalid;

  assign w_in_wait = (r_state == ST_WAIT_GNT);

  // A response arriving while nothing is outstanding is stray and ignored.
  assign w_rvalid = instr_rvalid_i & (r_outstanding != 3'd0);

  // Only the registered count gates issue: a same-cycle response does not
  // free a slot, keeping req independent of rvalid.
  assign w_can_issue = req_i & fifo_ready_i & (r_outstanding < MAX_OUT);

  // A parked request stays asserted whatever the core does meanwhile.
  assign instr_req_o  = rst_ni & (w_in_wait | w_can_issue);
  assign instr_addr_o = w_in_wait ? r_addr_hold : r_fetch_addr;
  assign w_grant      = instr_req_o & instr_gnt_i;

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = branch_i ? branch_addr_i : r_fetch_addr;
  assign fifo_valid_o = rst_ni & w_rvalid & (r_discard_cnt == 3'd0) & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;

  assign busy_o = rst_ni & ((r_outstanding != 3'd0) | w_in_wait);

  // Next FSM state: park in WAIT_GNT while a request is refused.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        if (instr_req_o && !instr_gnt_i) w_state_n = ST_WAIT_GNT;
        else                             w_state_n = ST_IDLE;
      end
      ST_WAIT_GNT: begin
        if (instr_gnt_i) w_state_n = ST_IDLE;
        else             w_state_n = ST_WAIT_GNT;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Next in-flight count, discard bookkeeping and fetch address.
  always_comb begin
    case ({w_grant, w_rvalid})
      2'b10:   w_outstanding_n = r_outstanding + 3'd1;
      2'b01:   w_outstanding_n = r_outstanding - 3'd1;
      default: w_outstanding_n = r_outstanding;
    endcase

    w_discard_cnt_n = r_discard_cnt;
    if (branch_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      w_discard_cnt_n = r_outstanding + {2'b00, w_grant} - {2'b00, w_rvalid};
    end else begin
      if (w_rvalid && (r_discard_cnt != 3'd0)) w_discard_cnt_n = w_discard_cnt_n - 3'd1;
      else                                     w_discard_cnt_n = w_discard_cnt_n;
      // A stale parked request only joins the drop count once it is granted.
      if (w_grant && r_discard_next) w_discard_cnt_n = w_discard_cnt_n + 3'd1;
      else                           w_discard_cnt_n = w_discard_cnt_n;
    end

    if (w_grant)                      w_discard_next_n = 1'b0;
    else if (branch_i && instr_req_o) w_discard_next_n = 1'b1;
    else                              w_discard_next_n = r_discard_next;

    // A stale grant fetched the old stream, so the new target is not consumed.
    if (branch_i)                          w_fetch_addr_n = {branch_addr_i[31:2], 2'b00};
    else if (w_grant && !r_discard_next)   w_fetch_addr_n = r_fetch_addr + 32'd4;
    else                                   w_fetch_addr_n = r_fetch_addr;

    if (!w_in_wait && instr_req_o && !instr_gnt_i) w_addr_hold_n = r_fetch_addr;
    else                                           w_addr_hold_n = r_addr_hold;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_outstanding  <= 3'd0;
      r_discard_cnt  <= 3'd0;
      r_discard_next <= 1'b0;
      r_fetch_addr   <= 32'd0;
      r_addr_hold    <= 32'd0;
    end else begin
      r_state        <= w_state_n;
      r_outstanding  <= w_outstanding_n;
      r_discard_cnt  <= w_discard_cnt_n;
      r_discard_next <= w_discard_next_n;
      r_fetch_addr   <= w_fetch_addr_n;
      r_addr_hold    <= w_addr_hold_n;
    end
  end

  ibex_fetch_req_scheduler_chk #(
    .MAX_OUT (MAX_OUT)
  ) u_chk (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_rvalid_i (instr_rvalid_i),
    .outstanding_i  (r_outstanding)
  );

endmodule

// ---------------------------------------------------------------------------
// ibex_fetch_req_scheduler_chk
//
// Protocol checks for the scheduler. A stray response is legal input (it is
// ignored) so it is only reported; an over-full in-flight count is an error.
// Ports: clk_i, rst_ni, instr_rvalid_i, outstanding_i (registered count).
// ---------------------------------------------------------------------------
module ibex_fetch_req_scheduler_chk #(
  parameter logic [2:0] MAX_OUT = 3'd2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       instr_rvalid_i,
  input  logic [2:0] outstanding_i
);

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_rvalid_i && (outstanding_i == 3'd0)))
    else $warning("ibex_fetch_req_scheduler: rvalid with nothing outstanding ignored");

  a_outstanding_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (outstanding_i <= MAX_OUT))
    else $error("ibex_fetch_req_scheduler: outstanding count above limit");

endmodule

// File: tb/tb_ibex_fetch_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ibex_fetch_req_scheduler
//
// Self-checking bench: directed scenarios followed by random stimulus, all
// checked cycle by cycle against a queue-based model of the fetch stream.
// ---------------------------------------------------------------------------
module tb_ibex_fetch_req_scheduler;

  localparam int N = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        busy_o;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic        fifo_ready_i;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_err_o;

  always #5 clk_i = ~clk_i;

  ibex_fetch_req_scheduler #(.NUM_REQS(N)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: responses in flight (oldest first, 1 = to be dropped),
  // an optional request parked waiting for grant, and the next fetch address.
  bit          m_q[$];
  bit          m_hold;
  bit          m_hold_stale;
  logic [31:0] m_hold_addr;
  logic [31:0] m_next;

  // Outputs sampled in the last cycle, for scenario-specific checks.
  logic        s_req, s_fvalid, s_clear, s_busy;
  logic [31:0] s_addr, s_faddr, s_rdata;
  logic [31:0] d_rdata;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hold       = 1'b0;
    m_hold_stale = 1'b0;
    m_hold_addr  = 32'd0;
    m_next       = 32'd0;
  endtask

  // Drive one cycle of inputs, check all outputs against the model at the
  // falling edge, then advance the model to the next cycle.
  task automatic run_cycle(input bit rq, input bit br, input logic [31:0] ba,
                           input bit gnt, input bit rv, input bit rdy);
    bit          e_req, e_valid, grant;
    logic [31:0] e_addr;
    bit          er;
    d_rdata        = $urandom();
    er             = 1'($urandom_range(0, 1));
    req_i          = rq;
    branch_i       = br;
    branch_addr_i  = ba;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = d_rdata;
    instr_err_i    = er;
    fifo_ready_i   = rdy;
    @(negedge clk_i);
    s_req = instr_req_o; s_addr = instr_addr_o; s_fvalid = fifo_valid_o;
    s_clear = fifo_clear_o; s_faddr = fifo_addr_o; s_busy = busy_o; s_rdata = fifo_rdata_o;
    if (!rst_ni) begin
      check_eq("rst_req", s_req, 32'd0);
      check_eq("rst_fifo_valid", s_fvalid, 32'd0);
      check_eq("rst_busy", s_busy, 32'd0);
      check_eq("rst_clear", s_clear, 32'(br));
      model_reset();
    end else begin
      e_req   = m_hold || (rq && rdy && (m_q.size() < N));
      e_addr  = m_hold ? m_hold_addr : m_next;
      e_valid = rv && (m_q.size() > 0) && !m_q[0] && !br;
      check_eq("instr_req", s_req, 32'(e_req));
      check_eq("instr_addr", s_addr, e_addr);
      check_eq("fifo_clear", s_clear, 32'(br));
      check_eq("fifo_addr", s_faddr, br ? ba : m_next);
      check_eq("fifo_valid", s_fvalid, 32'(e_valid));
      if (e_valid) begin
        check_eq("fifo_rdata", s_rdata, d_rdata);
        check_eq("fifo_err", 32'(fifo_err_o), 32'(er));
      end
      check_eq("busy", s_busy, 32'((m_q.size() != 0) || m_hold));
      grant = e_req && gnt;
      if (rv && (m_q.size() > 0)) void'(m_q.pop_front());
      if (grant) begin
        m_q.push_back(m_hold && m_hold_stale);
        if (!(m_hold && m_hold_stale)) m_next = m_next + 32'd4;
        m_hold       = 1'b0;
        m_hold_stale = 1'b0;
      end else if (e_req) begin
        if (!m_hold) begin
          m_hold      = 1'b1;
          m_hold_addr = m_next;
        end
        if (br) m_hold_stale = 1'b1;
      end
      if (br) begin
        foreach (m_q[i]) m_q[i] = 1'b1;
        m_next = ba & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    model_reset();
    rst_ni = 1'b0;
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    rst_ni = 1'b1;

    // Redirect to 0x100, then stream with gnt always high and rvalid a cycle later.
    run_cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 1'b0, 32'd0, 1'b1, i > 0, 1'b1);
      check_eq("stream_addr", s_addr, 32'h100 + 32'(4 * i));
      if (i > 0) check_eq("stream_valid", s_fvalid, 32'd1);
    end
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_eq("stream_last_valid", s_fvalid, 32'd1);

    // Grant withheld for three cycles while req_i toggles.
    for (int i = 0; i < 3; i++) begin
      run_cycle(i != 1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      check_eq("hold_req", s_req, 32'd1);
      check_eq("hold_addr", s_addr, 32'h10C);
    end
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check_eq("hold_grant_req", s_req, 32'd1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_eq("idle_after_grant", s_req, 32'd0);

    // Two outstanding, then branch to 0x202: both responses dropped.
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h202, 1'b1, 1'b0, 1'b1);
    check_eq("br_clear", s_clear, 32'd1);
    check_eq("br_fifo_addr", s_faddr, 32'h202);
    check_eq("br_full_no_req", s_req, 32'd0);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_eq("br_drop0", s_fvalid, 32'd0);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_eq("br_drop1", s_fvalid, 32'd0);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check_eq("br_next_addr", s_addr, 32'h200);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_eq("br_new_valid", s_fvalid, 32'd1);

    // Branch while parked at 0x40 with target 0x80.
    run_cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    check_eq("wait_br_addr", s_addr, 32'h40);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check_eq("wait_br_req", s_req, 32'd1);
    check_eq("wait_br_addr2", s_addr, 32'h40);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_eq("wait_br_drop", s_fvalid, 32'd0);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check_eq("wait_br_next", s_addr, 32'h80);

    // FIFO back-pressure stops issue but not delivery.
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    check_eq("bp_no_req", s_req, 32'd0);
    check_eq("bp_valid", s_fvalid, 32'd1);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check_eq("bp_no_req2", s_req, 32'd0);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check_eq("bp_resume", s_req, 32'd1);
    check_eq("bp_resume_addr", s_addr, 32'h84);

    // Address wrap, then reset mid-flight and a stray response.
    run_cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check_eq("wrap_addr_hi", s_addr, 32'hFFFF_FFFC);
    run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    check_eq("wrap_addr_lo", s_addr, 32'h0);
    rst_ni = 1'b0;
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    rst_ni = 1'b1;
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check_eq("stray_valid", s_fvalid, 32'd0);
    check_eq("post_rst_busy", s_busy, 32'd0);
    check_eq("post_rst_addr", s_addr, 32'h0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bit          rq, br, gnt, rv, rdy;
      logic [31:0] ba;
      rst_ni = ($urandom_range(0, 199) != 0);
      rq  = ($urandom_range(0, 9) < 8);
      br  = ($urandom_range(0, 9) == 0);
      ba  = $urandom() & 32'hFFFF_FFFE;
      gnt = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 8);
      rv  = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      run_cycle(rq, br, ba, gnt, rv, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
